// File: rtl/rv32_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch gets a registered taken/target prediction one cycle after presenting a PC.
module rv32_branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lookup_valid_in,
  input  logic [31:0] lookup_pc_in,
  output logic        predict_valid_out,
  output logic        predict_taken_out,
  output logic [31:0] predict_target_out,
  input  logic        update_valid_in,
  input  logic [31:0] update_pc_in,
  input  logic        update_taken_in,
  input  logic [31:0] update_target_in,
  input  logic        flush_in
);
  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS   = 30 - INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_d [ENTRIES];
  logic [30:0]         tgt_q [ENTRIES];
  logic [30:0]         tgt_d [ENTRIES];
  logic [1:0]          ctr_q [ENTRIES];
  logic [1:0]          ctr_d [ENTRIES];

  logic                pv_q, pv_d;
  logic                pt_q, pt_d;
  logic [31:0]         ptgt_q, ptgt_d;

  logic [INDEX_BITS-1:0] l_idx, u_idx;
  logic [TAG_BITS-1:0]   l_tag, u_tag;
  logic                  l_hit, u_hit;
  logic [31:0]           l_seq_pc;

  assign l_idx    = lookup_pc_in[INDEX_BITS+1:2];
  assign l_tag    = lookup_pc_in[31:INDEX_BITS+2];
  assign u_idx    = update_pc_in[INDEX_BITS+1:2];
  assign u_tag    = update_pc_in[31:INDEX_BITS+2];
  assign l_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign l_seq_pc = {lookup_pc_in[31:2], 2'b00} + 32'd4;

  // Lookup reads the current array, so a same-cycle update or flush is not seen.
  always_comb begin
    pv_d   = lookup_valid_in;
    pt_d   = 1'b0;
    ptgt_d = 32'h0;
    if (lookup_valid_in) begin
      if (l_hit && ctr_q[l_idx][1]) begin
        pt_d   = 1'b1;
        ptgt_d = {tgt_q[l_idx], 1'b0};
      end else begin
        ptgt_d = l_seq_pc;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < ENTRIES; i++) begin
      tag_d[i] = tag_q[i];
      tgt_d[i] = tgt_q[i];
      ctr_d[i] = ctr_q[i];
    end
    if (flush_in) begin
      valid_d = '0;
    end else if (update_valid_in) begin
      if (u_hit) begin
        if (update_taken_in) begin
          ctr_d[u_idx] = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
          tgt_d[u_idx] = update_target_in[31:1];
        end else begin
          ctr_d[u_idx] = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
      end else if (update_taken_in) begin
        // Taken miss replaces whatever lives at this index, starting weak-taken.
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = update_target_in[31:1];
        ctr_d[u_idx]   = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      pv_q    <= 1'b0;
      pt_q    <= 1'b0;
      ptgt_q  <= 32'h0;
    end else begin
      valid_q <= valid_d;
      pv_q    <= pv_d;
      pt_q    <= pt_d;
      ptgt_q  <= ptgt_d;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      tag_q[i] <= tag_d[i];
      tgt_q[i] <= tgt_d[i];
      ctr_q[i] <= ctr_d[i];
    end
  end

  assign predict_valid_out  = pv_q;
  assign predict_taken_out  = pt_q;
  assign predict_target_out = ptgt_q;
endmodule
